// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronizes a bouncing mechanical contact and only moves
// the clean level after the synchronized input has held its new value for
// STABLE_CYCLES consecutive cycles. Aborted transitions are counted.
module switch_debouncer #(
  parameter int STABLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       switch_raw,
  input  logic       clr_bounce,
  output logic       switch_clean,
  output logic       rise,
  output logic       fall,
  output logic [7:0] bounce_cnt
);

  // The run counter commits when it has already counted STABLE_CYCLES-1
  // matching cycles and sees one more.
  localparam logic [7:0] LastCount = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO,
    PEND_HI,
    STABLE_HI,
    PEND_LO
  } debounceState_t;

  logic           r_syncMeta;
  logic           r_swS;
  debounceState_t r_state;
  logic [7:0]     r_cnt;
  logic           r_clean;
  logic           r_rise;
  logic           r_fall;
  logic [7:0]     r_bounceCnt;

  debounceState_t w_nextState;
  logic [7:0]     w_nextCnt;
  logic           w_nextClean;
  logic           w_nextRise;
  logic           w_nextFall;
  logic           w_abort;
  logic [7:0]     w_nextBounceCnt;

  // Two-flop synchronizer for the asynchronous contact; it keeps running
  // regardless of the enable so the FSM always sees a fresh level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_syncMeta <= 1'b0;
      r_swS      <= 1'b0;
    end else begin
      r_syncMeta <= switch_raw;
      r_swS      <= r_syncMeta;
    end
  end

  // State, run counter, clean level, edge pulses and bounce counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= STABLE_LO;
      r_cnt       <= 8'd0;
      r_clean     <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_bounceCnt <= 8'd0;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_nextCnt;
      r_clean     <= w_nextClean;
      r_rise      <= w_nextRise;
      r_fall      <= w_nextFall;
      r_bounceCnt <= w_nextBounceCnt;
    end
  end

  // Next-state logic: a pending state either commits after enough matching
  // cycles, aborts on a mismatch (counted), or drops back silently when the
  // filter is disabled.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextClean = r_clean;
    w_nextRise  = 1'b0;
    w_nextFall  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      STABLE_LO: begin
        if (en && r_swS) begin
          w_nextState = PEND_HI;
          w_nextCnt   = 8'd1;
        end else begin
          w_nextCnt = 8'd0;
        end
      end
      PEND_HI: begin
        if (!en) begin
          w_nextState = STABLE_LO;
          w_nextCnt   = 8'd0;
        end else if (r_swS) begin
          if (r_cnt == LastCount) begin
            w_nextState = STABLE_HI;
            w_nextClean = 1'b1;
            w_nextRise  = 1'b1;
            w_nextCnt   = 8'd0;
          end else begin
            w_nextCnt = r_cnt + 8'd1;
          end
        end else begin
          w_nextState = STABLE_LO;
          w_nextCnt   = 8'd0;
          w_abort     = 1'b1;
        end
      end
      STABLE_HI: begin
        if (en && !r_swS) begin
          w_nextState = PEND_LO;
          w_nextCnt   = 8'd1;
        end else begin
          w_nextCnt = 8'd0;
        end
      end
      PEND_LO: begin
        if (!en) begin
          w_nextState = STABLE_HI;
          w_nextCnt   = 8'd0;
        end else if (!r_swS) begin
          if (r_cnt == LastCount) begin
            w_nextState = STABLE_LO;
            w_nextClean = 1'b0;
            w_nextFall  = 1'b1;
            w_nextCnt   = 8'd0;
          end else begin
            w_nextCnt = r_cnt + 8'd1;
          end
        end else begin
          w_nextState = STABLE_HI;
          w_nextCnt   = 8'd0;
          w_abort     = 1'b1;
        end
      end
      default: begin
        w_nextState = STABLE_LO;
        w_nextCnt   = 8'd0;
        w_nextClean = 1'b0;
      end
    endcase
  end

  // Bounce counter: clear has priority over an abort, and the count sticks at
  // its maximum instead of wrapping.
  always_comb begin
    w_nextBounceCnt = r_bounceCnt;
    if (clr_bounce) begin
      w_nextBounceCnt = 8'd0;
    end else if (w_abort && (r_bounceCnt != 8'hFF)) begin
      w_nextBounceCnt = r_bounceCnt + 8'd1;
    end
  end

  assign switch_clean = r_clean;
  assign rise         = r_rise;
  assign fall         = r_fall;
  assign bounce_cnt   = r_bounceCnt;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed testbench for switch_debouncer at the default STABLE_CYCLES of 8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_switch_debouncer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       switch_raw;
  logic       clr_bounce;
  logic       switch_clean;
  logic       rise;
  logic       fall;
  logic [7:0] bounce_cnt;

  int vectorCount;
  int failCount;
  int riseSeen;
  int fallSeen;
  int bothSeen;

  switch_debouncer #(.STABLE_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .switch_raw   (switch_raw),
    .clr_bounce   (clr_bounce),
    .switch_clean (switch_clean),
    .rise         (rise),
    .fall         (fall),
    .bounce_cnt   (bounce_cnt)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance a number of rising edges, tallying pulses seen after each edge.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (rise) riseSeen++;
      if (fall) fallSeen++;
      if (rise && fall) bothSeen++;
    end
  endtask

  // One comparison point: count it and report any difference.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectorCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearPulseCounts();
    riseSeen = 0;
    fallSeen = 0;
  endtask

  // Single short glitch: two raw-high cycles then three low cycles, enough to
  // enter PEND_HI and abort back to STABLE_LO.
  task automatic shortGlitch();
    switch_raw = 1'b1;
    applyStimulus(2);
    switch_raw = 1'b0;
    applyStimulus(3);
  endtask

  initial begin
    vectorCount = 0;
    failCount   = 0;
    riseSeen    = 0;
    fallSeen    = 0;
    bothSeen    = 0;
    rst_n       = 1'b0;
    en          = 1'b1;
    switch_raw  = 1'b0;
    clr_bounce  = 1'b0;

    // Reset state.
    applyStimulus(3);
    checkOutput("reset_clean", {7'd0, switch_clean}, 8'd0);
    checkOutput("reset_rise", {7'd0, rise}, 8'd0);
    checkOutput("reset_fall", {7'd0, fall}, 8'd0);
    checkOutput("reset_bounce", bounce_cnt, 8'd0);
    rst_n = 1'b1;
    applyStimulus(3);

    // Clean press: sampling edge plus 8 more edges leave the level unchanged,
    // the next edge commits it with a rise pulse.
    clearPulseCounts();
    switch_raw = 1'b1;
    applyStimulus(9);
    checkOutput("press_before_commit", {7'd0, switch_clean}, 8'd0);
    applyStimulus(1);
    checkOutput("press_clean", {7'd0, switch_clean}, 8'd1);
    checkOutput("press_rise", {7'd0, rise}, 8'd1);
    applyStimulus(1);
    checkOutput("press_rise_one_cycle", {7'd0, rise}, 8'd0);
    applyStimulus(9);
    checkOutput("press_rise_count", 8'(riseSeen), 8'd1);
    checkOutput("press_bounce", bounce_cnt, 8'd0);

    // Clean release mirrors the press with a fall pulse.
    clearPulseCounts();
    switch_raw = 1'b0;
    applyStimulus(9);
    checkOutput("release_before_commit", {7'd0, switch_clean}, 8'd1);
    applyStimulus(1);
    checkOutput("release_clean", {7'd0, switch_clean}, 8'd0);
    checkOutput("release_fall", {7'd0, fall}, 8'd1);
    checkOutput("release_rise_low", {7'd0, rise}, 8'd0);
    applyStimulus(5);
    checkOutput("release_fall_count", 8'(fallSeen), 8'd1);

    // Bouncy press: two short high bursts abort, then the held level commits.
    clearPulseCounts();
    switch_raw = 1'b1; applyStimulus(3);
    switch_raw = 1'b0; applyStimulus(3);
    switch_raw = 1'b1; applyStimulus(3);
    switch_raw = 1'b0; applyStimulus(3);
    switch_raw = 1'b1; applyStimulus(20);
    checkOutput("bouncy_clean", {7'd0, switch_clean}, 8'd1);
    checkOutput("bouncy_rise_count", 8'(riseSeen), 8'd1);
    checkOutput("bouncy_bounce", bounce_cnt, 8'd2);
    switch_raw = 1'b0;
    applyStimulus(15);
    checkOutput("bouncy_release", {7'd0, switch_clean}, 8'd0);

    // Clear, then a 5-cycle glitch must not move the level.
    clr_bounce = 1'b1;
    applyStimulus(1);
    clr_bounce = 1'b0;
    checkOutput("clear_bounce", bounce_cnt, 8'd0);
    clearPulseCounts();
    switch_raw = 1'b1; applyStimulus(5);
    switch_raw = 1'b0; applyStimulus(10);
    checkOutput("glitch_clean", {7'd0, switch_clean}, 8'd0);
    checkOutput("glitch_pulses", 8'(riseSeen + fallSeen), 8'd0);
    checkOutput("glitch_bounce", bounce_cnt, 8'd1);

    // Enable gate: disabled filter holds the level despite a steady high.
    clearPulseCounts();
    en = 1'b0;
    switch_raw = 1'b1;
    applyStimulus(30);
    checkOutput("gate_hold_clean", {7'd0, switch_clean}, 8'd0);
    checkOutput("gate_hold_pulses", 8'(riseSeen), 8'd0);
    en = 1'b1;
    applyStimulus(7);
    checkOutput("gate_before_commit", {7'd0, switch_clean}, 8'd0);
    applyStimulus(1);
    checkOutput("gate_clean", {7'd0, switch_clean}, 8'd1);
    checkOutput("gate_rise", {7'd0, rise}, 8'd1);

    // Disabling during PEND_LO returns to STABLE_HI without counting a bounce.
    applyStimulus(3);
    clearPulseCounts();
    switch_raw = 1'b0;
    applyStimulus(5);
    en = 1'b0;
    applyStimulus(20);
    checkOutput("gate_pend_clean", {7'd0, switch_clean}, 8'd1);
    checkOutput("gate_pend_bounce", bounce_cnt, 8'd1);
    checkOutput("gate_pend_pulses", 8'(fallSeen), 8'd0);
    en = 1'b1;
    applyStimulus(7);
    checkOutput("gate_fall_before", {7'd0, switch_clean}, 8'd1);
    applyStimulus(1);
    checkOutput("gate_fall_clean", {7'd0, switch_clean}, 8'd0);
    checkOutput("gate_fall_pulse", {7'd0, fall}, 8'd1);
    applyStimulus(3);

    // Saturation: 300 aborted glitches pin the counter at 255.
    for (int g = 0; g < 300; g++) shortGlitch();
    checkOutput("sat_bounce", bounce_cnt, 8'd255);
    checkOutput("sat_clean", {7'd0, switch_clean}, 8'd0);

    // Clear held across a glitch abort: the clear must win.
    clr_bounce = 1'b1;
    shortGlitch();
    clr_bounce = 1'b0;
    checkOutput("clear_vs_abort", bounce_cnt, 8'd0);

    // Mid-operation reset while pending high with the contact held high.
    shortGlitch();
    checkOutput("pre_reset_bounce", bounce_cnt, 8'd1);
    switch_raw = 1'b1;
    applyStimulus(5);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_clean", {7'd0, switch_clean}, 8'd0);
    checkOutput("midrst_rise", {7'd0, rise}, 8'd0);
    checkOutput("midrst_fall", {7'd0, fall}, 8'd0);
    checkOutput("midrst_bounce", bounce_cnt, 8'd0);
    applyStimulus(2);
    rst_n = 1'b1;
    clearPulseCounts();
    applyStimulus(9);
    checkOutput("postrst_no_spurious", 8'(riseSeen), 8'd0);
    checkOutput("postrst_before_commit", {7'd0, switch_clean}, 8'd0);
    applyStimulus(1);
    checkOutput("postrst_clean", {7'd0, switch_clean}, 8'd1);
    checkOutput("postrst_rise", {7'd0, rise}, 8'd1);
    applyStimulus(5);
    checkOutput("postrst_rise_count", 8'(riseSeen), 8'd1);
    checkOutput("postrst_bounce", bounce_cnt, 8'd0);

    // rise and fall must never be high in the same cycle.
    checkOutput("never_both", 8'(bothSeen), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
